tile_ppu_core: RTL and testbench
================================

// Module: tile_ppu_core
// PURPOSE
//  Tile-based picture processing unit for the 1024x600 HDMI path.
//  - CPU side: writes and reads tilemap, pattern RAM, palette and control registers.
//  - Video side: given the encoder's cursor position, returns a 24-bit RGB pixel.
//  - Single clock domain; the caller supplies the clock, so CPU/pixel CDC is handled outside.
// PARAMETERS
//  H_ACTIVE  1024  visible pixels per line
//  V_ACTIVE  600   visible lines
//  TILE_W    8     tile edge in pixels (fixed 8x8, 4bpp)
// PORTS
//  clkout      in   1   system/pixel clock, all logic on rising edge
//  ext_reset   in   1   asynchronous, active-low reset
//  ren         in   1   CPU read strobe
//  wen         in   1   CPU write strobe
//  address     in   16  CPU byte address
//  data_in     in   32  CPU write data
//  byte_select in   4   write lane enables; bit n -> data_in[8n+7:8n]
//  data_out    out  32  registered read data
//  xcursor     in   14  current pixel column
//  ycursor     in   14  current pixel line
//  is_blank    in   1   blanking interval active
//  color_out   out  24  RGB {R[23:16],G[15:8],B[7:0]}
// BEHAVIOUR
//  Reset:
//  - Outputs: color_out=0, data_out=0.
//  - Registers: CTRL=0, BGCOLOR=0, SCROLL=0.
//  - RAM contents are not cleared.
//  Memory map (address bits [1:0] select the lane):
//  - 0x0000-0x257F tilemap: 128x75 tile indices, 1 byte each, index = row*128+col.
//  - 0x4000-0x5FFF pattern RAM: 256 tiles x 32 B. Byte = tile*32 + row*4 + col/2.
//    Low nibble is the even (left) pixel.
//  - 0x8000-0x803F palette: 16 words, bits [23:0] RGB; [31:24] read 0.
//  - 0xC000 CTRL: bit0 = display enable.
//  - 0xC004 BGCOLOR: [23:0].
//  - 0xC008 SCROLL: [9:0] scroll_x, [25:16] scroll_y.
//  Writes:
//  - Take effect when wen=1; only lanes with byte_select=1 are written.
//  - Writes to unmapped addresses are ignored.
//  - Registers and palette honour byte lanes.
//  Reads:
//  - ren=1 at cycle N -> data_out valid at N+1, as a word-aligned 32-bit word.
//  - Unmapped addresses read 0.
//  - data_out holds its value while ren=0.
//  - Simultaneous ren+wen to the same address returns the old data.
//  Pixel pipeline, latency 2 (cursor at N -> color_out at N+2):
//  - Stage 1: compute effective x,y, then fetch the tile index.
//  - Stage 2: fetch the pattern byte and select the nibble.
//  - Stage 3: palette lookup, then the output register.
//  - Pixel index 0 outputs BGCOLOR; index k>0 outputs palette[k].
//  - color_out=0 when any of these holds: is_blank=1, CTRL.bit0=0, xcursor>=1024, or ycursor>=600.
//  - These conditions are delayed with the pipeline.
//  - CPU writes have priority in time only. The video read port is separate (dual-port RAM).
//  - A pixel fetched in the same cycle as a write to that location shows the old value.
// CONFIGURATION
//  PPU_SCROLL_EN defined:
//  - x_eff = (x + scroll_x) mod 1024.
//  - y_eff = y + scroll_y, minus 600 if the sum is >= 600.
//  - scroll_y writes >= 600 saturate to 599.
//  PPU_SCROLL_EN undefined:
//  - SCROLL reads 0 and writes are ignored; x_eff=x, y_eff=y.
// TESTING
//  - Reset: pulse ext_reset low mid-frame -> color_out=0, data_out=0, read 0xC000 -> 0.
//  - Register RW: write 0x00FF8040 to 0xC004, byte_select=4'b0011 -> read back 0x00008040.
//  - Tile render:
//    - Setup: tilemap[0]=1, pattern byte 0x4020 = 0x21, palette[1]=0xFF0000, palette[2]=0x00FF00, CTRL=1.
//    - Cursor (0,0) -> color_out 0xFF0000 two cycles later.
//    - Cursor (1,0) -> 0x00FF00.
//  - Background/blank: index 0 with BGCOLOR=0x123456 -> 0x123456; is_blank=1 -> 0.
//  - Bounds: ycursor=600 or xcursor=1024 -> 0. Unmapped read 0x3000 -> 0.
//  - Scroll (PPU_SCROLL_EN): scroll_x=1020, cursor x=10 -> pixel of column 6.
//    scroll_y=700 -> stored and read back as 599.

Source files
------------

// File: rtl/tile_ppu_core_if.sv
// CPU bus and video cursor/pixel signals of the tile PPU, grouped as one interface.
// master = CPU/encoder side, slave = the PPU core.
interface tile_ppu_core_if;
  logic        ren;
  logic        wen;
  logic [15:0] address;
  logic [31:0] data_in;
  logic [3:0]  byte_select;
  logic [31:0] data_out;
  logic [13:0] xcursor;
  logic [13:0] ycursor;
  logic        is_blank;
  logic [23:0] color_out;

  modport master (
    output ren, wen, address, data_in, byte_select, xcursor, ycursor, is_blank,
    input  data_out, color_out
  );

  modport slave (
    input  ren, wen, address, data_in, byte_select, xcursor, ycursor, is_blank,
    output data_out, color_out
  );
endinterface

// File: rtl/tile_ppu_core.sv
// Tile PPU: 128x75 tilemap of 8x8 4bpp tiles, 16-entry palette, 2-cycle pixel pipeline.
// Optional hardware scrolling is enabled with the PPU_SCROLL_EN macro.
module tile_ppu_core #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 600,
  parameter int TILE_W   = 8
) (
  input logic             clkout,
  input logic             ext_reset,
  tile_ppu_core_if.slave  bus
);

  localparam int TMAP_WORDS = 2400;
  localparam int PAT_WORDS  = 2048;
  localparam int STAGES     = 1;
  localparam int TSH        = $clog2(TILE_W);
  localparam logic [13:0] HMAX  = 14'(H_ACTIVE);
  localparam logic [13:0] VMAX  = 14'(V_ACTIVE);
  localparam logic [6:0]  TROWS = 7'(V_ACTIVE / TILE_W);

  logic [3:0][7:0] tmap_q [TMAP_WORDS];
  logic [3:0][7:0] pat_q  [PAT_WORDS];
  logic [23:0]     pal_q  [16];

  logic        ctrl_en_q;
  logic [23:0] bg_q;
  logic [31:0] data_out_q, rd_d;
  logic [23:0] color_q, color_d;
`ifdef PPU_SCROLL_EN
  logic [9:0]  sx_q, sy_q, sy_d;
  logic [31:0] scr_m;
`endif

  function automatic logic [31:0] merge_be(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // ---------------- CPU decode ----------------
  logic [15:0] a;
  logic [31:0] din;
  logic [3:0]  be;
  logic        sel_tmap, sel_pat, sel_pal, sel_ctrl, sel_bg, sel_scr;
  logic [31:0] bg_m, pal_m;

  assign a        = bus.address;
  assign din      = bus.data_in;
  assign be       = bus.byte_select;
  assign sel_tmap = a < 16'h2580;
  assign sel_pat  = a[15:13] == 3'b010;
  assign sel_pal  = a[15:6] == 10'h200;
  assign sel_ctrl = a[15:2] == 14'h3000;
  assign sel_bg   = a[15:2] == 14'h3001;
  assign sel_scr  = a[15:2] == 14'h3002;
  assign bg_m     = merge_be({8'h0, bg_q}, din, be);
  assign pal_m    = merge_be({8'h0, pal_q[a[5:2]]}, din, be);

  always_comb begin
    rd_d = '0;
    if (sel_tmap)      rd_d = tmap_q[a[13:2]];
    else if (sel_pat)  rd_d = pat_q[a[12:2]];
    else if (sel_pal)  rd_d = {8'h0, pal_q[a[5:2]]};
    else if (sel_ctrl) rd_d = {31'h0, ctrl_en_q};
    else if (sel_bg)   rd_d = {8'h0, bg_q};
`ifdef PPU_SCROLL_EN
    else if (sel_scr)  rd_d = {6'h0, sy_q, 6'h0, sx_q};
`endif
  end

`ifdef PPU_SCROLL_EN
  assign scr_m = merge_be({6'h0, sy_q, 6'h0, sx_q}, din, be);
  // Out-of-range vertical scroll is clamped so the single wrap subtraction below suffices.
  assign sy_d  = (scr_m[25:16] >= 10'(V_ACTIVE)) ? 10'(V_ACTIVE - 1) : scr_m[25:16];
`endif

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      ctrl_en_q  <= 1'b0;
      bg_q       <= '0;
      data_out_q <= '0;
`ifdef PPU_SCROLL_EN
      sx_q       <= '0;
      sy_q       <= '0;
`endif
    end else begin
      if (bus.wen) begin
        if (sel_ctrl && be[0]) ctrl_en_q <= din[0];
        if (sel_bg)            bg_q      <= bg_m[23:0];
`ifdef PPU_SCROLL_EN
        if (sel_scr) begin
          sx_q <= scr_m[9:0];
          sy_q <= sy_d;
        end
`endif
      end
      if (bus.ren) data_out_q <= rd_d;
    end
  end

  // ---------------- pixel pipeline ----------------
  logic [13:0] x, y;
  logic [9:0]  xe, ye;
  logic [6:0]  trow, tcol;
  logic [11:0] tw;
  logic [STAGES:0] vld_pipe;
  logic [7:0]  tile_q;
  logic [2:0]  prow_q, pcol_q;
  logic [7:0]  pbyte;
  logic [3:0]  nib;

  assign x = bus.xcursor;
  assign y = bus.ycursor;

`ifdef PPU_SCROLL_EN
  logic [10:0] ysum;
  assign xe   = x[9:0] + sx_q;
  assign ysum = {1'b0, y[9:0]} + {1'b0, sy_q};
  assign ye   = (ysum >= 11'(V_ACTIVE)) ? 10'(ysum - 11'(V_ACTIVE)) : ysum[9:0];
`else
  assign xe = x[9:0];
  assign ye = y[9:0];
`endif

  assign trow = 7'(ye >> TSH);
  assign tcol = 7'(xe >> TSH);
  // Off-screen rows would index past the tilemap; their pixel is masked anyway.
  assign tw   = (trow < TROWS) ? {trow, tcol[6:2]} : '0;
  assign vld_pipe[0] = !bus.is_blank && ctrl_en_q && (x < HMAX) && (y < VMAX);

  always_ff @(posedge clkout) begin
    if (bus.wen && sel_tmap)
      for (int i = 0; i < 4; i++) if (be[i]) tmap_q[a[13:2]][i] <= din[8*i +: 8];
    if (bus.wen && sel_pat)
      for (int i = 0; i < 4; i++) if (be[i]) pat_q[a[12:2]][i] <= din[8*i +: 8];
    if (bus.wen && sel_pal) pal_q[a[5:2]] <= pal_m[23:0];
    tile_q <= tmap_q[tw][tcol[1:0]];
    prow_q <= ye[2:0];
    pcol_q <= xe[2:0];
  end

  assign pbyte   = pat_q[{tile_q, prow_q}][pcol_q[2:1]];
  assign nib     = pcol_q[0] ? pbyte[7:4] : pbyte[3:0];
  assign color_d = !vld_pipe[STAGES] ? 24'h0 : (nib == 4'h0) ? bg_q : pal_q[nib];

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      vld_pipe[STAGES:1] <= '0;
      color_q            <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      color_q            <= color_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.color_out = color_q;

  logic unused_bits;
`ifdef PPU_SCROLL_EN
  assign unused_bits = ^{a[1:0], bg_m[31:24], pal_m[31:24], scr_m[31:26], scr_m[15:10]};
`else
  assign unused_bits = ^{a[1:0], bg_m[31:24], pal_m[31:24], sel_scr};
`endif

endmodule

// File: tb/tb_tile_ppu_core.sv
// Scoreboard bench for tile_ppu_core: stimulus pushes expected read/pixel values,
// a negedge monitor pops and compares them when the DUT output becomes due.
module tb_tile_ppu_core;
  logic clkout = 1'b0;
  logic ext_reset = 1'b0;
  always #5 clkout = ~clkout;

  tile_ppu_core_if bus();
  tile_ppu_core dut (.clkout(clkout), .ext_reset(ext_reset), .bus(bus));

  typedef struct {
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t rdq[$];
  item_t pixq[$];
  item_t it;
  logic chk_rd = 1'b0, chk_pix = 1'b0, chk_now = 1'b0, fin_chk = 1'b0;
  logic rd_t = 1'b0;
  logic [1:0] pix_t = 2'b00;
  logic [31:0] now_d, now_c;
  string now_name;
  int ncmp = 0;
  int nerr = 0;

  // Due-tags: read data is due 1 cycle after ren, pixels 2 cycles after the cursor.
  always @(posedge clkout) begin
    rd_t  <= chk_rd;
    pix_t <= {pix_t[0], chk_pix};
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  always @(negedge clkout) begin
    if (rd_t) begin
      if (rdq.size() == 0) cmp("rd_unexpected", bus.data_out, 32'hDEADBEEF);
      else begin
        it = rdq.pop_front();
        cmp(it.name, bus.data_out, it.exp);
      end
    end
    if (pix_t[1]) begin
      if (pixq.size() == 0) cmp("pix_unexpected", {8'h0, bus.color_out}, 32'hDEADBEEF);
      else begin
        it = pixq.pop_front();
        cmp(it.name, {8'h0, bus.color_out}, it.exp);
      end
    end
    if (chk_now) begin
      cmp({now_name, "_dout"}, bus.data_out, now_d);
      cmp({now_name, "_color"}, {8'h0, bus.color_out}, now_c);
    end
    if (fin_chk) cmp("queues_drained", 32'(rdq.size() + pixq.size()), 32'd0);
  end

  task automatic tick();
    @(posedge clkout);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wen = 1'b1; bus.address = a; bus.data_in = d; bus.byte_select = be;
    tick();
    bus.wen = 1'b0; bus.byte_select = 4'h0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string nm);
    bus.ren = 1'b1; bus.address = a; chk_rd = 1'b1;
    rdq.push_back('{exp, nm});
    tick();
    bus.ren = 1'b0; chk_rd = 1'b0;
  endtask

  task automatic rdwr(input logic [15:0] a, input logic [31:0] d, input logic [31:0] exp,
                      input string nm);
    bus.ren = 1'b1; bus.wen = 1'b1; bus.address = a; bus.data_in = d;
    bus.byte_select = 4'hF; chk_rd = 1'b1;
    rdq.push_back('{exp, nm});
    tick();
    bus.ren = 1'b0; bus.wen = 1'b0; bus.byte_select = 4'h0; chk_rd = 1'b0;
  endtask

  task automatic pix(input int px, input int py, input logic blank, input logic [23:0] exp,
                     input string nm);
    bus.xcursor = 14'(px); bus.ycursor = 14'(py); bus.is_blank = blank; chk_pix = 1'b1;
    pixq.push_back('{{8'h0, exp}, nm});
    tick();
    chk_pix = 1'b0; bus.is_blank = 1'b0;
  endtask

  task automatic now(input logic [31:0] d, input logic [31:0] c, input string nm);
    now_d = d; now_c = c; now_name = nm; chk_now = 1'b1;
    @(negedge clkout);
    #1 chk_now = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.ren = 0; bus.wen = 0; bus.address = 0; bus.data_in = 0; bus.byte_select = 0;
    bus.xcursor = 0; bus.ycursor = 0; bus.is_blank = 0;
    repeat (3) tick();
    now(32'h0, 32'h0, "reset_init");
    ext_reset = 1'b1;
    tick();

    // registers, unmapped space, palette upper byte
    wr(16'hC004, 32'h00FF8040, 4'b0011);
    rd(16'hC004, 32'h00008040, "bg_lanes");
    rd(16'h3000, 32'h0, "unmapped");
    wr(16'h3000, 32'hFFFFFFFF, 4'hF);
    rd(16'h3000, 32'h0, "unmapped_wr");
    wr(16'h8004, 32'hAAFF0000, 4'hF);
    rd(16'h8004, 32'h00FF0000, "pal1_hi0");
    wr(16'h8008, 32'h0000FF00, 4'hF);
    wr(16'h800C, 32'h000000FF, 4'hF);

    // tilemap: col0,row0 -> tile1; col0,row1 -> tile1; col5,row0 -> tile1
    wr(16'h0000, 32'h00000001, 4'hF);
    wr(16'h0080, 32'h00000001, 4'hF);
    wr(16'h0004, 32'h00000100, 4'hF);
    // tile1 row0: px0=1 px1=2 px6=3; row1: px0=2
    wr(16'h4020, 32'h03000021, 4'hF);
    wr(16'h4024, 32'h00000012, 4'hF);
    wr(16'hC004, 32'h00123456, 4'hF);
    wr(16'hC000, 32'h00000001, 4'b0001);
    rd(16'h0000, 32'h00000001, "tmap_rb");
    rd(16'h4020, 32'h03000021, "pat_rb");
    rd(16'hC000, 32'h00000001, "ctrl_rb");
    repeat (3) tick();
    now(32'h00000001, 32'h00FF0000, "dout_hold");

    pix(0, 0, 1'b0, 24'hFF0000, "px_0_0");
    pix(1, 0, 1'b0, 24'h00FF00, "px_1_0");
    pix(2, 0, 1'b0, 24'h123456, "px_bg");
    pix(6, 0, 1'b0, 24'h0000FF, "px_6_0");
    pix(0, 1, 1'b0, 24'h00FF00, "px_prow1");
    pix(0, 8, 1'b0, 24'hFF0000, "px_trow1");
    pix(40, 0, 1'b0, 24'hFF0000, "px_tcol5_a");
    pix(41, 0, 1'b0, 24'h00FF00, "px_tcol5_b");
    pix(0, 0, 1'b1, 24'h000000, "px_blank");
    pix(0, 600, 1'b0, 24'h000000, "px_ybound");
    pix(1024, 0, 1'b0, 24'h000000, "px_xbound");
    pix(1023, 599, 1'b1, 24'h000000, "px_corner_blank");
    pix(1, 0, 1'b0, 24'h00FF00, "px_after_bounds");

    rdwr(16'hC004, 32'h00654321, 32'h00123456, "rw_old_data");
    rd(16'hC004, 32'h00654321, "rw_new_data");

`ifdef PPU_SCROLL_EN
    wr(16'hC008, 32'h000003FC, 4'hF);
    pix(10, 0, 1'b0, 24'h0000FF, "scroll_x_wrap");
    wr(16'hC008, 32'h02BC03FC, 4'hF);
    rd(16'hC008, 32'h025703FC, "scroll_y_sat");
    pix(10, 1, 1'b0, 24'h0000FF, "scroll_y_wrap");
    wr(16'hC008, 32'h00000000, 4'hF);
`else
    wr(16'hC008, 32'h02BC03FC, 4'hF);
    rd(16'hC008, 32'h0, "scroll_off");
`endif

    // mid-frame reset with display on
    bus.xcursor = 0; bus.ycursor = 0;
    repeat (3) tick();
    ext_reset = 1'b0;
    now(32'h0, 32'h0, "reset_mid");
    tick();
    ext_reset = 1'b1;
    tick();
    rd(16'hC000, 32'h0, "ctrl_after_rst");
    pix(0, 0, 1'b0, 24'h000000, "px_disp_off");

    for (int g = 0; g < 20 && (rdq.size() + pixq.size()) != 0; g++) tick();
    repeat (3) tick();
    fin_chk = 1'b1;
    @(negedge clkout);
    #1 fin_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
